gpio_input: RTL
===============

GPIO_INPUT -- requirements
Module: gpio_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive cycles a synchronized input must differ from its debounced value before the debounced value changes; legal range 2..1023.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port btn_start, input, 1 bit: raw, asynchronous, bouncing start push-button, 1 = pressed.
REQ-005 Port sw, input, 4 bits: raw, asynchronous, bouncing mode switches.
REQ-006 Port busy, input, 1 bit: accelerator busy, synchronous to clk.
REQ-007 Port start_ack, input, 1 bit: accelerator acknowledge of start_req, synchronous, single-cycle or longer.
REQ-008 Port start_req, output, 1 bit: registered start request to the accelerator.
REQ-009 Port mode, output, 4 bits: registered debounced sw value captured when a request is issued.
REQ-010 Port btn_db, output, 1 bit: registered debounced button level.
REQ-011 Port sw_db, output, 4 bits: registered debounced switch levels.

Function
REQ-012 Each of the 5 raw inputs shall pass through its own 2-flop synchronizer before any other use.
REQ-013 Each bit shall have an independent counter of width clog2(DEBOUNCE_CYCLES+1).
- Any cycle where the synchronized bit equals its debounced bit: clear the counter.
- Otherwise: increment the counter.
- When the counter would reach DEBOUNCE_CYCLES: toggle the debounced bit and clear the counter.
REQ-014 The counter shall never wrap.
REQ-015 Latency: a raw change stable from clock edge k shall appear on the debounced output at edge k+2+DEBOUNCE_CYCLES.
REQ-016 A press event shall be a one-cycle internal pulse on the 0->1 transition of btn_db; a level held high shall produce no further events.
REQ-017 FSM states: IDLE, REQ, HOLD.
REQ-018 IDLE transitions:
- On a press event with busy=0: go to REQ and capture mode<=sw_db in the same edge.
- On a press event with busy=1: discard the event, stay in IDLE, leave mode unchanged, queue nothing.
REQ-019 start_req shall be 1 exactly while in REQ; it shall rise one edge after the btn_db rising edge.
REQ-020 REQ transitions:
- On start_ack=1: go to HOLD, with start_req low from the next edge.
- busy changing while in REQ: no effect.
REQ-021 HOLD transitions: go to IDLE when btn_db=0; press events cannot occur in HOLD.
REQ-022 start_ack while in IDLE or HOLD shall be ignored.
REQ-023 A sw change after capture shall not alter mode until the next accepted request.

Reset
REQ-024 While rst=0, all of the following shall be 0 asynchronously: synchronizer flops, counters, btn_db, sw_db, start_req, mode; FSM = IDLE.
REQ-025 After rst deasserts with the button already held, one press event shall occur at 2+DEBOUNCE_CYCLES edges, and start_req one edge later if busy=0.
REQ-026 Reset asserted during REQ shall drop start_req immediately, without waiting for start_ack.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset: rst=0 with random inputs -> start_req=0, mode=0000, btn_db=0, sw_db=0000.
REQ-028 Clean press: sw=1010 settled, busy=0, btn_start 0->1 held -> btn_db=1 at edge 6; start_req=1 at edge 7 with mode=1010; start_ack pulse -> start_req=0 next edge.
REQ-029 Bounce: btn_start toggles every 2 cycles for 20 cycles then settles at 1 -> exactly one start_req assertion; btn_db never glitches during the toggling.
REQ-030 Busy: busy=1 during the press, then busy drops while the button is still held -> start_req stays 0; release and re-press with busy=0 -> one request.
REQ-031 Held button: after ack with the button still held -> no second start_req until btn_db falls and a new press debounces.
REQ-032 Reset in REQ: rst=0 with start_req=1 -> start_req=0 within the same cycle; release rst with the button held -> start_req=1 at edge 7 after release.

Source files
------------

// File: rtl/gpio_input.sv
// Button/switch front end: synchronizes and debounces the raw inputs, then issues
// a start request to the accelerator on each accepted button press.
module gpio_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic [3:0] sw,
  input  logic       busy,
  input  logic       start_ack,
  output logic       start_req,
  output logic [3:0] mode,
  output logic       btn_db,
  output logic [3:0] sw_db
);

  localparam int unsigned NumIn = 5;
  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);
  // Toggle happens on the edge where the count would reach DEBOUNCE_CYCLES.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  logic [NumIn-1:0]           raw;
  logic [NumIn-1:0]           sync1_q, sync2_q;
  logic [NumIn-1:0]           db_q, db_d;
  logic [NumIn-1:0][CntW-1:0] cnt_q, cnt_d;
  logic                       btn_prev_q;
  logic                       press;
  logic                       accept;
  state_e                     state_q, state_d;
  logic [3:0]                 mode_q, mode_d;

  // Bit 0 is the button, bits 4:1 the switches.
  assign raw = {sw, btn_start};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NumIn; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        cnt_d[i] = '0;
        db_d[i]  = ~db_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q       <= '0;
      cnt_q      <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= db_q[0];
    end
  end

  assign press  = db_q[0] & ~btn_prev_q;
  assign accept = (state_q == StIdle) && press && !busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StReq;
      StReq:   if (start_ack) state_d = StHold;
      StHold:  if (!db_q[0]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    if (accept) mode_d = db_q[4:1];
  end

  always_comb begin
    start_req = (state_q == StReq);
    mode      = mode_q;
    btn_db    = db_q[0];
    sw_db     = db_q[4:1];
  end

endmodule
